f_issue_collect: RTL and testbench

- Initiator for the single-op FPU wrapper handshake: up_valid/res/down_valid/busy/error.
- Accepts operand pairs over a valid/ready interface and issues them to an FPU wrapper such as the adder, multiplier or divider.
- Collects each result and its error bit into an in-order result FIFO, presented downstream on a valid/ready interface.
- Credit-based issue means a unit result is never dropped, because the wrappers have no back-pressure.

---
 rtl/f_issue_collect_if.sv | 32 +++
 rtl/f_issue_collect.sv | 122 ++++++++++++
 tb/tb_f_issue_collect.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_issue_collect_if.sv
// Handshake bundle between f_issue_collect, its operand/result clients and one FPU wrapper.
// The master side is the collector; the slave side is the environment around it.
interface f_issue_collect_if #(
  parameter int FLEN = 64
);
  logic            arg_vld;
  logic            arg_rdy;
  logic [FLEN-1:0] arg_a;
  logic [FLEN-1:0] arg_b;
  logic [FLEN-1:0] unit_a;
  logic [FLEN-1:0] unit_b;
  logic            unit_up_valid;
  logic [FLEN-1:0] unit_res;
  logic            unit_down_valid;
  logic            unit_busy;
  logic            unit_error;
  logic            res_vld;
  logic            res_rdy;
  logic [FLEN-1:0] res_data;
  logic            res_err;
  logic            proto_err;

  modport master (
    input  arg_vld, arg_a, arg_b, unit_res, unit_down_valid, unit_busy, unit_error, res_rdy,
    output arg_rdy, unit_a, unit_b, unit_up_valid, res_vld, res_data, res_err, proto_err
  );

  modport slave (
    output arg_vld, arg_a, arg_b, unit_res, unit_down_valid, unit_busy, unit_error, res_rdy,
    input  arg_rdy, unit_a, unit_b, unit_up_valid, res_vld, res_data, res_err, proto_err
  );
endinterface

// File: rtl/f_issue_collect.sv
// Credit-based issue/collect front end for a single-op FPU wrapper; results return in order via a FIFO.
// Define F_ISSUE_COLLECT_TIMEOUT_EN to add the TIMEOUT watchdog and its sticky timeout output.
module f_issue_collect #(
  parameter int FLEN      = 64,
  parameter int DEPTH     = 4,
  parameter int PIPELINED = 1
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 256
`endif
) (
  input  logic              clk,
  input  logic              rst,
  f_issue_collect_if.master bus
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic            pend_q;
  logic [CW-1:0]   infl_q, infl_d, occ_q, occ_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [FLEN-1:0] a_q, b_q;
  logic [FLEN-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0] mem_err_q;
  logic            proto_q, proto_d;
  logic [CW:0]     used;
  logic            idle, tmo_blk;
  logic            acc, iss, ret, unexp, full, pop, push, ovf;

  // Every accepted op owns a FIFO slot from accept to pop, so a return always has room.
  assign used = (CW+1)'(pend_q) + (CW+1)'(infl_q) + (CW+1)'(occ_q);
  assign idle = !pend_q && (infl_q == '0);

  assign bus.arg_rdy = !rst && !bus.unit_busy && (used < (CW+1)'(DEPTH)) &&
                       ((PIPELINED != 0) || idle) && !tmo_blk;

  assign acc   = bus.arg_vld && bus.arg_rdy;
  assign iss   = pend_q && !rst;
  assign ret   = bus.unit_down_valid && (infl_q != '0);
  assign unexp = bus.unit_down_valid && (infl_q == '0);
  assign full  = (occ_q == CW'(DEPTH));
  assign pop   = bus.res_vld && bus.res_rdy;
  assign push  = ret && (!full || pop);
  assign ovf   = ret && full && !pop;

  assign infl_d  = infl_q + CW'(iss) - CW'(ret);
  assign occ_d   = occ_q + CW'(push) - CW'(pop);
  assign proto_d = proto_q || unexp || ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      infl_q    <= '0;
      occ_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      proto_q   <= 1'b0;
      mem_err_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_data_q[i] <= '0;
    end else begin
      pend_q  <= acc;
      infl_q  <= infl_d;
      occ_q   <= occ_d;
      proto_q <= proto_d;
      if (acc) begin
        a_q <= bus.arg_a;
        b_q <= bus.arg_b;
      end
      if (push) begin
        mem_data_q[wptr_q] <= bus.unit_res;
        mem_err_q[wptr_q]  <= bus.unit_error;
        wptr_q             <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign bus.unit_up_valid = iss;
  assign bus.unit_a        = rst ? '0 : a_q;
  assign bus.unit_b        = rst ? '0 : b_q;
  assign bus.res_vld       = !rst && (occ_q != '0);
  assign bus.res_data      = rst ? '0 : mem_data_q[rptr_q];
  assign bus.res_err       = !rst && mem_err_q[rptr_q];
  assign bus.proto_err     = !rst && proto_q;

`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_q, outst;

  // The up_valid cycle already counts as outstanding, so the flag rises TIMEOUT cycles after it.
  assign outst = (infl_q != '0) || iss;

  always_comb begin
    tcnt_d = tcnt_q;
    if (!outst || bus.unit_down_valid) tcnt_d = '0;
    else if (tcnt_q != TW'(TIMEOUT))   tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_q || (tcnt_d == TW'(TIMEOUT));
    end
  end

  assign tmo_blk = tmo_q;
  assign timeout = tmo_q && !rst;
`else
  assign tmo_blk = 1'b0;
`endif
endmodule

// File: tb/tb_f_issue_collect.sv
// Bench for f_issue_collect: a pipelined and an iterative instance, each driven by a latency-queue unit model.
// The expectations come from op counts (accepted / returned / popped) and an in-order result scoreboard.
module tb_f_issue_collect;
  localparam int FLEN  = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f_issue_collect_if #(.FLEN(FLEN)) bp ();
  f_issue_collect_if #(.FLEN(FLEN)) bs ();
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
  logic tmo_p, tmo_s;
`endif

  f_issue_collect #(.FLEN(FLEN), .DEPTH(DEPTH), .PIPELINED(1)
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_pipe (
    .clk(clk), .rst(rst), .bus(bp)
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
    , .timeout(tmo_p)
`endif
  );

  f_issue_collect #(.FLEN(FLEN), .DEPTH(DEPTH), .PIPELINED(0)) u_iter (
    .clk(clk), .rst(rst), .bus(bs)
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
    , .timeout(tmo_s)
`endif
  );

  typedef struct {
    int              t;
    logic [FLEN-1:0] r;
    logic            e;
  } ret_t;

  typedef struct {
    logic            vld;
    logic [FLEN-1:0] a, b;
    logic            rr;
    logic            e_rdy, e_up, e_rv;
    logic [FLEN-1:0] e_rd;
    logic            e_re;
  } vec_t;

  ret_t            sched [2][$];
  logic [FLEN:0]   exq   [2][$];
  int              acc_n [2], iss_n [2], ret_n [2], pop_n [2];
  int              last_t [2], lat [2], busy_len [2], busy_rem [2], max_fl [2];
  bit              pip [2], rnd_busy [2], force_dv [2], exp_proto [2], acc_prev [2];
  logic [FLEN-1:0] a_prev [2], b_prev [2];
  bit              errp [2][256];
  bit              rnd_lat, gen_en;
  int              cyc, nvec, nerr;

  logic            o_rdy [2], o_up [2], o_rv [2], o_re [2], o_pe [2], o_tm [2];
  logic [FLEN-1:0] o_ua [2], o_ub [2], o_rd [2];
  logic            d_vld [2], d_rr [2];
  logic [FLEN-1:0] d_a [2], d_b [2];

  function automatic logic [FLEN-1:0] fop(logic [FLEN-1:0] a, logic [FLEN-1:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [FLEN-1:0] rval();
    return $realtobits(real'($urandom_range(0, 4000)) / 8.0);
  endfunction

  task automatic chk(string nm, logic [FLEN:0] act, logic [FLEN:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_model(int k);
    sched[k].delete();
    exq[k].delete();
    acc_n[k] = 0; iss_n[k] = 0; ret_n[k] = 0; pop_n[k] = 0;
    last_t[k] = 0; busy_rem[k] = 0; max_fl[k] = 0;
    exp_proto[k] = 0; acc_prev[k] = 0;
  endtask

  // Compare one instance against the count-level model, then account for this cycle's events.
  task automatic m_upd(int k, logic dv, logic bz);
    string p = (k == 0) ? "pipe" : "iter";
    ret_t  s;
    bit    e_rdy;
    if (rst) begin
      chk({p, ".rst_arg_rdy"}, o_rdy[k], 0);
      chk({p, ".rst_up_valid"}, o_up[k], 0);
      chk({p, ".rst_unit_ab"}, {o_ua[k] | o_ub[k]}, 0);
      chk({p, ".rst_res_vld"}, o_rv[k], 0);
      chk({p, ".rst_res"}, {o_re[k], o_rd[k]}, 0);
      chk({p, ".rst_proto"}, o_pe[k], 0);
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
      chk({p, ".rst_timeout"}, o_tm[k], 0);
`endif
      clr_model(k);
      return;
    end
    if (gen_en) begin
      e_rdy = !bz && (acc_n[k] - pop_n[k] < DEPTH) && (pip[k] || acc_n[k] == ret_n[k]);
      chk({p, ".arg_rdy"}, o_rdy[k], e_rdy);
      chk({p, ".up_valid"}, o_up[k], acc_prev[k]);
      if (acc_prev[k]) chk({p, ".unit_ab"}, {o_ua[k], o_ub[k]}, {a_prev[k], b_prev[k]});
      chk({p, ".res_vld"}, o_rv[k], ret_n[k] != pop_n[k]);
      chk({p, ".proto_err"}, o_pe[k], exp_proto[k]);
    end
    if (o_rv[k] && d_rr[k] && exq[k].size() > 0) begin
      chk({p, ".result"}, {o_re[k], o_rd[k]}, exq[k][0]);
      void'(exq[k].pop_front());
      pop_n[k]++;
    end
    if (dv) begin
      if (iss_n[k] > ret_n[k]) ret_n[k]++;
      else exp_proto[k] = 1;
    end
    if (busy_rem[k] > 0) busy_rem[k]--;
    if (o_up[k]) begin
      s.t = cyc + (rnd_lat ? $urandom_range(1, 6) : lat[k]);
      if (s.t <= last_t[k]) s.t = last_t[k] + 1;
      s.r = fop(o_ua[k], o_ub[k]);
      s.e = errp[k][iss_n[k] % 256];
      last_t[k] = s.t;
      sched[k].push_back(s);
      iss_n[k]++;
      if (busy_len[k] > 0) busy_rem[k] = busy_len[k];
      if (iss_n[k] - ret_n[k] > max_fl[k]) max_fl[k] = iss_n[k] - ret_n[k];
    end
    acc_prev[k] = d_vld[k] && o_rdy[k];
    if (acc_prev[k]) begin
      exq[k].push_back({errp[k][acc_n[k] % 256], fop(d_a[k], d_b[k])});
      acc_n[k]++;
      a_prev[k] = d_a[k];
      b_prev[k] = d_b[k];
    end
  endtask

  // One clock: drive at the falling edge, observe 1 ns later, return 1 ns after the rising edge.
  task automatic step();
    logic            dv [2], de [2], bz [2];
    logic [FLEN-1:0] dr [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dv[k] = 0; de[k] = 0; dr[k] = '0;
      if (!rst && sched[k].size() > 0 && sched[k][0].t <= cyc) begin
        dv[k] = 1; dr[k] = sched[k][0].r; de[k] = sched[k][0].e;
        void'(sched[k].pop_front());
      end
      if (force_dv[k]) begin
        dv[k] = 1; dr[k] = 64'hDEAD_BEEF_0BAD_F00D; de[k] = 1; force_dv[k] = 0;
      end
      bz[k] = (busy_rem[k] > 0) || (rnd_busy[k] && $urandom_range(0, 3) == 0);
    end
    bp.arg_vld = d_vld[0]; bp.arg_a = d_a[0]; bp.arg_b = d_b[0]; bp.res_rdy = d_rr[0];
    bp.unit_down_valid = dv[0]; bp.unit_res = dr[0]; bp.unit_error = de[0]; bp.unit_busy = bz[0];
    bs.arg_vld = d_vld[1]; bs.arg_a = d_a[1]; bs.arg_b = d_b[1]; bs.res_rdy = d_rr[1];
    bs.unit_down_valid = dv[1]; bs.unit_res = dr[1]; bs.unit_error = de[1]; bs.unit_busy = bz[1];
    #1;
    o_rdy[0] = bp.arg_rdy; o_up[0] = bp.unit_up_valid; o_ua[0] = bp.unit_a; o_ub[0] = bp.unit_b;
    o_rv[0] = bp.res_vld; o_rd[0] = bp.res_data; o_re[0] = bp.res_err; o_pe[0] = bp.proto_err;
    o_rdy[1] = bs.arg_rdy; o_up[1] = bs.unit_up_valid; o_ua[1] = bs.unit_a; o_ub[1] = bs.unit_b;
    o_rv[1] = bs.res_vld; o_rd[1] = bs.res_data; o_re[1] = bs.res_err; o_pe[1] = bs.proto_err;
`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
    o_tm[0] = tmo_p; o_tm[1] = tmo_s;
`else
    o_tm[0] = 0; o_tm[1] = 0;
`endif
    for (int k = 0; k < 2; k++) m_upd(k, dv[k], bz[k]);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tv [6];
    int   sent, base, got;
    logic [2:0] errs;

    nvec = 0; nerr = 0; cyc = 0; gen_en = 1; rnd_lat = 0;
    pip[0] = 1; pip[1] = 0;
    for (int k = 0; k < 2; k++) begin
      clr_model(k);
      lat[k] = 2; busy_len[k] = 0; rnd_busy[k] = 0; force_dv[k] = 0;
      d_vld[k] = 0; d_rr[k] = 1; d_a[k] = '0; d_b[k] = '0;
      for (int i = 0; i < 256; i++) errp[k][i] = 0;
    end
    rst = 1;
    step(); step();
    rst = 0;

    // Single op through the pipelined instance, latency-2 adder model.
    tv[0] = '{1, 64'h3FF0000000000000, 64'h4000000000000000, 1, 1, 0, 0, 64'h0, 0};
    tv[1] = '{0, 64'h0, 64'h0, 1, 1, 1, 0, 64'h0, 0};
    tv[2] = '{0, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0, 0};
    tv[3] = '{0, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0, 0};
    tv[4] = '{0, 64'h0, 64'h0, 1, 1, 0, 1, 64'h4008000000000000, 0};
    tv[5] = '{0, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0, 0};
    for (int i = 0; i < 6; i++) begin
      d_vld[0] = tv[i].vld; d_a[0] = tv[i].a; d_b[0] = tv[i].b; d_rr[0] = tv[i].rr;
      step();
      chk($sformatf("tv%0d.arg_rdy", i), o_rdy[0], tv[i].e_rdy);
      chk($sformatf("tv%0d.up_valid", i), o_up[0], tv[i].e_up);
      chk($sformatf("tv%0d.res_vld", i), o_rv[0], tv[i].e_rv);
      chk($sformatf("tv%0d.res", i), {o_re[0], o_rd[0]}, {tv[i].e_re, tv[i].e_rd});
    end

    // Back-pressure: six pairs offered with the result side stalled.
    d_rr[0] = 0; sent = 0;
    for (int i = 0; i < 12; i++) begin
      d_vld[0] = (sent < 6); d_a[0] = $realtobits(real'(sent + 10)); d_b[0] = $realtobits(0.5);
      step();
      if (d_vld[0] && o_rdy[0]) sent++;
    end
    chk("bp.accepts_while_stalled", sent, 4);
    chk("bp.arg_rdy_stalled", o_rdy[0], 0);
    base = pop_n[0]; d_rr[0] = 1;
    for (int i = 0; i < 60 && pop_n[0] - base < 6; i++) begin
      d_vld[0] = (sent < 6); d_a[0] = $realtobits(real'(sent + 10)); d_b[0] = $realtobits(0.5);
      step();
      if (d_vld[0] && o_rdy[0]) sent++;
    end
    d_vld[0] = 0;
    chk("bp.total_pops", pop_n[0] - base, 6);

    // Error bit on the middle of three ops.
    base = acc_n[0];
    errp[0][(base + 1) % 256] = 1;
    sent = 0; got = 0; errs = '0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      d_vld[0] = (sent < 3); d_a[0] = rval(); d_b[0] = rval();
      step();
      if (d_vld[0] && o_rdy[0]) sent++;
      if (o_rv[0] && d_rr[0]) begin errs[2 - got] = o_re[0]; got++; end
    end
    d_vld[0] = 0;
    errp[0][(base + 1) % 256] = 0;
    chk("err.sequence", errs, 3'b010);
    chk("err.proto_err", o_pe[0], 0);

    // Iterative instance with a busy unit.
    busy_len[1] = 10; lat[1] = 11; base = pop_n[1]; sent = 0;
    for (int i = 0; i < 100 && pop_n[1] - base < 3; i++) begin
      d_vld[1] = (sent < 3); d_a[1] = rval(); d_b[1] = rval();
      step();
      if (d_vld[1] && o_rdy[1]) sent++;
    end
    d_vld[1] = 0; busy_len[1] = 0;
    chk("iter.pops", pop_n[1] - base, 3);
    chk("iter.max_in_flight", max_fl[1], 1);

    // Return with nothing outstanding.
    force_dv[0] = 1;
    step();
    step();
    chk("unexp.proto_err", o_pe[0], 1);
    chk("unexp.res_vld", o_rv[0], 0);

    // Reset with two ops in flight.
    lat[0] = 20; sent = 0;
    for (int i = 0; i < 8 && sent < 2; i++) begin
      d_vld[0] = 1; d_a[0] = rval(); d_b[0] = rval();
      step();
      if (o_rdy[0]) sent++;
    end
    d_vld[0] = 0;
    step(); step();
    chk("rst.in_flight_before", iss_n[0] - ret_n[0], 2);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst.after_arg_rdy", o_rdy[0], 1);
    chk("rst.after_up_valid", o_up[0], 0);
    chk("rst.after_unit_a", o_ua[0], 0);
    chk("rst.after_res_vld", o_rv[0], 0);
    chk("rst.after_res", {o_re[0], o_rd[0]}, 0);
    chk("rst.after_proto", o_pe[0], 0);
    lat[0] = 2;
    for (int i = 0; i < 25; i++) step();

    // Randomized traffic on both instances.
    rnd_lat = 1; rnd_busy[0] = 1; rnd_busy[1] = 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) errp[k][i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 2; k++) begin
        d_vld[k] = ($urandom_range(0, 9) < 7);
        d_rr[k]  = ($urandom_range(0, 9) < 6);
        d_a[k] = rval(); d_b[k] = rval();
      end
      step();
    end
    rnd_busy[0] = 0; rnd_busy[1] = 0;
    for (int k = 0; k < 2; k++) begin d_vld[k] = 0; d_rr[k] = 1; end
    for (int i = 0; i < 100 && (exq[0].size() + exq[1].size()) > 0; i++) step();
    chk("drain.pipe_left", exq[0].size(), 0);
    chk("drain.iter_left", exq[1].size(), 0);
    chk("drain.pipe_counts", pop_n[0], acc_n[0]);
    chk("drain.iter_counts", pop_n[1], acc_n[1]);
    rnd_lat = 0;

`ifdef F_ISSUE_COLLECT_TIMEOUT_EN
    // Watchdog: one op that never returns.
    rst = 1; step(); rst = 0;
    gen_en = 0; lat[0] = 100000;
    d_vld[0] = 1; d_a[0] = rval(); d_b[0] = rval();
    step();
    d_vld[0] = 0;
    step();
    chk("tmo.up_valid", o_up[0], 1);
    got = 0;
    for (int j = 1; j <= 40 && got == 0; j++) begin
      step();
      if (o_tm[0]) got = j;
    end
    chk("tmo.cycles_after_up", got, 16);
    d_vld[0] = 1;
    step(); step();
    chk("tmo.arg_rdy", o_rdy[0], 0);
    chk("tmo.sticky", o_tm[0], 1);
    d_vld[0] = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
